multi_lane_fir: RTL and testbench
=================================

MULTI_LANE_FIR -- requirements
Module: multi_lane_fir

Interface
REQ-001 The block SHALL have parameter LANES, default 3, meaning the number of samples accepted per clock.
REQ-002 The block SHALL have parameter TAPS, default 8, meaning the FIR filter length; legal values are TAPS >= 2.
REQ-003 The block SHALL have parameter DIN_W, default 16, meaning the signed input sample width.
REQ-004 The block SHALL have parameter COEF_W, default 16, meaning the signed coefficient width.
REQ-005 The block SHALL have parameter DOUT_W, default 64, meaning the signed output width; legal values are DOUT_W >= DIN_W+COEF_W+clog2(TAPS).
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit, the reset; it is synchronous and active-low (0 = reset).
REQ-008 The block SHALL have port in_valid, input, 1 bit, meaning din carries a valid beat this cycle.
REQ-009 The block SHALL have port din, input, LANES*DIN_W bits; lane j is at bits [j*DIN_W +: DIN_W] and holds sample n = L*k+j of beat k.
REQ-010 The block SHALL have port clear, input, 1 bit, a synchronous flush of the sample history.
REQ-011 The block SHALL have port coef_we, input, 1 bit, a coefficient write strobe.
REQ-012 The block SHALL have port coef_addr, input, clog2(TAPS) bits, the index of the tap to write.
REQ-013 The block SHALL have port coef_data, input, COEF_W bits, the signed coefficient value.
REQ-014 The block SHALL have port out_valid, output, 1 bit, meaning dout carries a valid beat.
REQ-015 The block SHALL have port dout, output, LANES*DIN_W-style packing of LANES*DOUT_W bits; lane j is at [j*DOUT_W +: DOUT_W].

Function
REQ-016 Per lane, the block SHALL compute y[n] = sum over i=0..TAPS-1 of h[i]*x[n-i]; x is the accepted-sample stream in order, lane 0 first within a beat.
REQ-017 The block SHALL hold a history of the last TAPS-1 accepted samples and shift it by LANES samples only on a cycle with in_valid=1.
REQ-018 Cycles with in_valid=0 SHALL be bubbles: the history is held, no sample is consumed, and results are identical to a gapless stream.
REQ-019 The block SHALL be a 2-stage pipeline: stage 1 registers all LANES*TAPS products, and stage 2 registers the per-lane adder-tree sum.
REQ-020 out_valid SHALL assert exactly 2 cycles after an accepted in_valid beat; dout holds its last value when out_valid=0. There is no backpressure.
REQ-021 Products and sums SHALL be full-precision signed, sign-extended to DOUT_W, with no rounding or saturation.
REQ-022 When coef_we=1, the write SHALL update h[coef_addr] at the clock edge; the new value applies to beats accepted from the next cycle on.
REQ-023 A beat accepted in the same cycle as a coefficient write SHALL use the old coefficient, and beats already in the pipeline SHALL be unaffected.
REQ-024 When coef_addr >= TAPS, the write SHALL be ignored.
REQ-025 When clear=1, the block SHALL zero the history at the clock edge.
REQ-026 When clear=1 and in_valid=1 in the same cycle, the beat SHALL be computed with zero history and the history SHALL then hold only that beat's samples.
REQ-027 clear SHALL NOT affect coefficients, in-flight pipeline beats, or out_valid.

Reset
REQ-028 While rst=0 at a clock edge, the block SHALL clear history, coefficients, all pipeline registers, out_valid and dout to 0, and ignore in_valid, coef_we and clear.
REQ-029 When reset is asserted mid-stream, in-flight beats SHALL be discarded: no out_valid for them after reset.
REQ-030 The first beat accepted after rst returns to 1 SHALL see zero history.

Verification
REQ-031 Impulse test (defaults, h[i]=i+1): write h[0..7]=1..8, then send beat (1,0,0) followed by two zero beats -> dout beats (1,2,3), (4,5,6), (7,8,0), with out_valid at cycles +2, +3 and +4.
REQ-032 Bubble test: repeat the REQ-031 stream with 2 idle cycles between beats -> identical dout values, with out_valid=1 only 2 cycles after each beat.
REQ-033 Extreme-value test: all h=-32768, continuous beats of -32768 -> after the history fills, every lane = 8589934592 with no overflow.
REQ-034 Coefficient-timing test: write h[0]=2 in the same cycle as beat (5,0,0) -> y0=old h[0]*5; the next beat (5,0,0) -> y0=10.
REQ-035 Clear/reset test: assert clear with beat (1,0,0) after nonzero history -> output equals the pure REQ-031 impulse response; drop rst for 1 cycle mid-stream -> out_valid=0 and dout=0 next cycle, with coefficients read as 0 (all-zero outputs).

Source files
------------

// File: rtl/multi_lane_fir.sv
// Multi-lane FIR filter: LANES samples per beat, TAPS-long shared history,
// two-stage pipeline (registered products, then registered per-lane sums).
module multi_lane_fir #(
  parameter int unsigned LANES  = 3,
  parameter int unsigned TAPS   = 8,
  parameter int unsigned DIN_W  = 16,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned DOUT_W = 64,
  localparam int unsigned AW    = $clog2(TAPS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [LANES*DIN_W-1:0]  din,
  input  logic                    clear,
  input  logic                    coef_we,
  input  logic [AW-1:0]           coef_addr,
  input  logic [COEF_W-1:0]       coef_data,
  output logic                    out_valid,
  output logic [LANES*DOUT_W-1:0] dout
);

  localparam int unsigned PW = DIN_W + COEF_W;
  localparam int unsigned WN = TAPS - 1 + LANES;

  logic [DIN_W-1:0]  hist_q [TAPS-1];
  logic [DIN_W-1:0]  hist_d [TAPS-1];
  logic [COEF_W-1:0] coef_q [TAPS];
  logic [COEF_W-1:0] coef_d [TAPS];
  logic [DOUT_W-1:0] prod_q [LANES][TAPS];
  logic [DOUT_W-1:0] prod_d [LANES][TAPS];
  logic [DOUT_W-1:0] sum_q  [LANES];
  logic [DOUT_W-1:0] sum_d  [LANES];
  logic              v1_q, v1_d;
  logic              out_valid_q, out_valid_d;

  // Sample window, oldest first: TAPS-1 history samples then this beat's lanes.
  logic [DIN_W-1:0]  win [WN];
  logic [DIN_W-1:0]  wx;
  logic [PW-1:0]     p;
  logic [DOUT_W-1:0] acc;

  always_comb begin
    wx  = '0;
    p   = '0;
    acc = '0;
    for (int m = 0; m < TAPS - 1; m++) begin
      win[TAPS-2-m] = clear ? '0 : hist_q[m];
    end
    for (int j = 0; j < LANES; j++) begin
      win[TAPS-1+j] = din[j*DIN_W +: DIN_W];
    end
    // hist[0] is the most recent sample.
    for (int m = 0; m < TAPS - 1; m++) begin
      hist_d[m] = in_valid ? win[TAPS-2+LANES-m] : win[TAPS-2-m];
    end

    coef_d = coef_q;
    if (coef_we && ({{(32-AW){1'b0}}, coef_addr} < TAPS)) begin
      coef_d[coef_addr] = coef_data;
    end

    for (int j = 0; j < LANES; j++) begin
      for (int i = 0; i < TAPS; i++) begin
        wx = win[TAPS-1+j-i];
        p  = {{COEF_W{wx[DIN_W-1]}}, wx} * {{DIN_W{coef_q[i][COEF_W-1]}}, coef_q[i]};
        prod_d[j][i] = {{(DOUT_W-PW){p[PW-1]}}, p};
      end
    end
    v1_d = in_valid;

    for (int j = 0; j < LANES; j++) begin
      acc = '0;
      for (int i = 0; i < TAPS; i++) begin
        acc = acc + prod_q[j][i];
      end
      sum_d[j] = v1_q ? acc : sum_q[j];
    end
    out_valid_d = v1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int m = 0; m < TAPS - 1; m++) hist_q[m] <= '0;
      for (int i = 0; i < TAPS; i++) coef_q[i] <= '0;
      for (int j = 0; j < LANES; j++) begin
        for (int i = 0; i < TAPS; i++) prod_q[j][i] <= '0;
        sum_q[j] <= '0;
      end
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      coef_q <= coef_d;
      if (in_valid) prod_q <= prod_d;
      sum_q       <= sum_d;
      v1_q        <= v1_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      dout[j*DOUT_W +: DOUT_W] = sum_q[j];
    end
  end
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_multi_lane_fir.sv
// Bench for multi_lane_fir: directed literal checks plus randomized traffic
// compared every cycle against a sample-stream reference model.
module tb_multi_lane_fir;
  localparam int L  = 3;
  localparam int T  = 8;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int OW = 64;
  localparam int AW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            clear = 1'b0;
  logic            coef_we = 1'b0;
  logic [L*DW-1:0] din = '0;
  logic [AW-1:0]   coef_addr = '0;
  logic [CW-1:0]   coef_data = '0;
  logic            out_valid;
  logic [L*OW-1:0] dout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  longint          h [T];
  longint          hs[$];
  int              due_q[$];
  logic [L*OW-1:0] y_q[$];
  logic [L*OW-1:0] last_y = '0;
  longint          obs[$];
  longint          mlog[$];

  always #5 clk = ~clk;

  multi_lane_fir #(
    .LANES (L),
    .TAPS  (T),
    .DIN_W (DW),
    .COEF_W(CW),
    .DOUT_W(OW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .din      (din),
    .clear    (clear),
    .coef_we  (coef_we),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .out_valid(out_valid),
    .dout     (dout)
  );

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: y[n] = sum h[i]*x[n-i] over the accepted stream, zero before reset/clear.
  task automatic model_step();
    longint s[L];
    longint y;
    longint x;
    logic [L*OW-1:0] yv;
    cyc++;
    if (!rst) begin
      for (int i = 0; i < T; i++) h[i] = 0;
      hs.delete();
      due_q.delete();
      y_q.delete();
      last_y = '0;
      return;
    end
    if (in_valid) begin
      if (clear) hs.delete();
      for (int j = 0; j < L; j++) s[j] = longint'($signed(din[j*DW +: DW]));
      yv = '0;
      for (int j = 0; j < L; j++) begin
        y = 0;
        for (int i = 0; i < T; i++) begin
          if (i <= j) x = s[j-i];
          else if (i - j <= hs.size()) x = hs[hs.size()-(i-j)];
          else x = 0;
          y += h[i] * x;
        end
        yv[j*OW +: OW] = y;
        mlog.push_back(y);
      end
      due_q.push_back(cyc + 1);
      y_q.push_back(yv);
      for (int j = 0; j < L; j++) hs.push_back(s[j]);
      while (hs.size() > T - 1) void'(hs.pop_front());
    end else if (clear) begin
      hs.delete();
    end
    if (coef_we && int'(coef_addr) < T) h[coef_addr] = longint'($signed(coef_data));
  endtask

  task automatic compare_step();
    logic ev;
    ev = (due_q.size() > 0) && (due_q[0] == cyc);
    chk("out_valid", longint'(out_valid), longint'(ev));
    if (ev) begin
      void'(due_q.pop_front());
      last_y = y_q.pop_front();
      for (int j = 0; j < L; j++) obs.push_back(longint'($signed(dout[j*OW +: OW])));
    end
    for (int j = 0; j < L; j++) begin
      chk("dout_lane", longint'($signed(dout[j*OW +: OW])), longint'($signed(last_y[j*OW +: OW])));
    end
  endtask

  always @(posedge clk) model_step();
  always @(negedge clk) if (cyc > 0) compare_step();

  task automatic step();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
    coef_we  = 1'b0;
  endtask

  task automatic send(longint a, longint b, longint c, logic clr = 1'b0);
    din      = {16'(c), 16'(b), 16'(a)};
    in_valid = 1'b1;
    clear    = clr;
    step();
  endtask

  task automatic wcoef(int a, longint d);
    coef_we   = 1'b1;
    coef_addr = 3'(a);
    coef_data = 16'(d);
    step();
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic expect_obs(string name, int idx, longint e);
    if (idx < obs.size()) begin
      chk(name, obs[idx], e);
    end else begin
      total++;
      bad++;
      $display("FAIL %s: no output beat at index %0d, expected %0d", name, idx, e);
    end
  endtask

  longint imp[9] = '{1, 2, 3, 4, 5, 6, 7, 8, 0};

  initial begin
    rst = 1'b0;
    idle(3);
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_dout", longint'($signed(dout[OW-1:0])), 0);
    rst = 1'b1;

    for (int i = 0; i < T; i++) wcoef(i, i + 1);
    obs.delete();
    mlog.delete();
    send(1, 0, 0);
    send(0, 0, 0);
    send(0, 0, 0);
    idle(4);
    for (int k = 0; k < 9; k++) begin
      expect_obs("impulse", k, imp[k]);
      chk("impulse_model", mlog[k], imp[k]);
    end

    obs.delete();
    send(1, 0, 0);
    idle(2);
    send(0, 0, 0);
    idle(2);
    send(0, 0, 0);
    idle(4);
    for (int k = 0; k < 9; k++) expect_obs("bubble", k, imp[k]);

    obs.delete();
    mlog.delete();
    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 16'd2;
    send(5, 0, 0);
    send(5, 0, 0, 1'b1);
    idle(4);
    expect_obs("coef_old", 0, 5);
    expect_obs("coef_new", 3, 10);
    chk("coef_old_model", mlog[0], 5);
    chk("coef_new_model", mlog[3], 10);
    wcoef(0, 1);

    send(100, -200, 300);
    send(-7, 11, 13);
    send(9, 9, 9);
    idle(4);
    obs.delete();
    send(1, 0, 0, 1'b1);
    send(0, 0, 0);
    send(0, 0, 0);
    idle(4);
    for (int k = 0; k < 9; k++) expect_obs("clear_impulse", k, imp[k]);

    for (int i = 0; i < T; i++) wcoef(i, -32768);
    obs.delete();
    send(-32768, -32768, -32768, 1'b1);
    repeat (9) send(-32768, -32768, -32768);
    idle(4);
    for (int k = 3; k < 10; k++) begin
      for (int j = 0; j < L; j++) expect_obs("extreme", 3 * k + j, 64'sd8589934592);
    end

    send(1, 2, 3);
    send(4, 5, 6);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("midreset_out_valid", longint'(out_valid), 0);
    for (int j = 0; j < L; j++) chk("midreset_dout", longint'($signed(dout[j*OW +: OW])), 0);
    obs.delete();
    send(7, 8, 9);
    send(1, 1, 1);
    idle(4);
    for (int k = 0; k < 6; k++) expect_obs("zero_coef", k, 0);

    for (int i = 0; i < T; i++) wcoef(i, longint'($signed(16'($urandom()))));
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 199) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      din       = 48'({$urandom(), $urandom()});
      clear     = ($urandom_range(0, 19) == 0);
      coef_we   = ($urandom_range(0, 7) == 0);
      coef_addr = 3'($urandom());
      coef_data = 16'($urandom());
      step();
    end
    rst = 1'b1;
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
